riscv_dbg_ctrl: RTL and testbench
=================================

Name: riscv_dbg_ctrl

Overview:
- Synthesizable run-control sequencer between the GDB stub command side and the CPU debug handshake (dbg_req/dbg_grt).
- Halts, resumes, single-steps and resets the CPU; owns a small hardware breakpoint bank.
- Reports every stop with a GDB signal code so the stub can answer "?" and stop replies.
- Sits beside the CPU in the testbench top; the stub drives the cmd_* interface.

Parameters:
XLEN, 32, PC width
BPN, 4, number of hardware breakpoints (1..16)
RST_CYC, 4, cycles cpu_rst is held
TMO, 1024, halt-acknowledge timeout in cycles

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cmd_vld  input  1  command valid
cmd_rdy  output  1  command ready; transfer when cmd_vld&cmd_rdy
cmd_op  input  3  NOP=0, HALT=1, RESUME=2, STEP=3, RESET=4, BP_SET=5, BP_CLR=6
cmd_idx  input  $clog2(BPN)  breakpoint index
cmd_adr  input  XLEN  breakpoint address
dbg_req  output  1  halt request to CPU (level)
dbg_grt  input  1  CPU halted acknowledge (level)
cpu_rst  output  1  CPU reset
ret_vld  input  1  instruction retired
ret_pc  input  XLEN  PC of retired instruction
ret_ill  input  1  retired instruction was illegal (qualified by ret_vld)
sts_vld  output  1  one-cycle stop/alarm event pulse
sts_sig  output  8  signal code of last event (held)
sts_run  output  1  1 in RUN/STEP states

Behaviour:
- Reset (rst=1): state=RST, cpu_rst=1, dbg_req=1, cmd_rdy=0, sts_vld=0, sts_sig=SIGTRAP(5), sts_run=0, all breakpoints disabled, counters zero.
- RST: count RST_CYC cycles, then cpu_rst=0 and go to HREQ with pending sig SIGTRAP.
- HREQ:
  - dbg_req=1.
  - On dbg_grt=1: go to HALTED; pulse sts_vld with pending sig in the same transition (registered, visible the cycle HALTED is entered).
  - Timeout counter increments each HREQ cycle. At TMO: one sts_vld pulse with sig SIGALRM(14), keep waiting; counter saturates.
- HALTED:
  - dbg_req=1, cmd_rdy=1.
  - RESUME: go to RLS with next=RUN.
  - STEP: go to RLS with next=STEP.
  - RESET: go to RST.
  - BP_SET/BP_CLR: write slot cmd_idx (address + enable); stay.
  - HALT and NOP: accepted, no effect.
- RLS: dbg_req=0, cmd_rdy=0. When dbg_grt=0, go to next.
- RUN:
  - dbg_req=0, cmd_rdy=1.
  - Accepted HALT: HREQ, sig SIGINT(2).
  - Accepted RESET: RST.
  - BP_SET/BP_CLR: allowed.
  - RESUME/STEP/NOP: ignored.
  - ret_vld with ret_ill: HREQ, sig SIGILL(4).
  - ret_vld with ret_pc matching an enabled breakpoint: HREQ, sig SIGTRAP.
  - Stop is after-retire: the matching instruction has executed.
- STEP:
  - dbg_req=0, cmd_rdy=0.
  - First ret_vld: HREQ, sig SIGILL if ret_ill, else SIGTRAP.
  - dbg_req rises the following cycle.
- Same-cycle priority: ret_ill > breakpoint > accepted HALT command. The command is still consumed.
- Breakpoint compare: full XLEN equality. Any enabled slot matching is a hit. Writes to a slot take effect the cycle after the transfer.
- dbg_grt dropping while HALTED: ignored; state stays HALTED.
- rst mid-operation: forces RST, clears breakpoints, aborts any pending stop event (no sts_vld).

Decomposition:
- Package riscv_dbg_pkg holds:
  - cmd_op_t enum.
  - ctl_state_t enum {RST, HREQ, HALTED, RLS, RUN, STEP}.
  - sig_t byte codes SIGINT/SIGILL/SIGTRAP/SIGALRM, shared with the GDB stub.
- One sub-module, riscv_dbg_bp:
  - BPN address/enable registers, write port, XLEN comparators.
  - hit output, combinational from ret_pc.

Test Plan:
- Reset release: rst high 2 cycles, dbg_grt tied to dbg_req delayed 1 cycle. Required: cpu_rst high 4 cycles, then sts_vld with sts_sig=8'h05, state HALTED, cmd_rdy=1.
- Resume/halt: RESUME from HALTED, then HALT while in RUN. Required: dbg_req falls, sts_run=1; after HALT, dbg_req rises, sts_vld with sts_sig=8'h02.
- Breakpoint: BP_SET idx 0 adr 32'h0000_0100, RESUME, retire PCs 0xF8, 0xFC, 0x100. Required: dbg_req rises the cycle after 0x100 retires, sts_sig=8'h05. A cleared slot (BP_CLR) on a rerun produces no stop.
- Single step: STEP from HALTED, retire 0x104 then keep issuing retires. Required: exactly one retire runs before dbg_req=1, sts_sig=8'h05.
- Priority/illegal: in RUN, the same cycle carries ret_vld, ret_ill=1, ret_pc=bp address and an accepted HALT. Required: sts_sig=8'h04.
- Timeout: HALT with dbg_grt held 0 for TMO+10 cycles. Required: a single sts_vld with sts_sig=8'h0E at TMO, still HREQ. Raising dbg_grt then gives a stop with sts_sig=8'h02.

Source files
------------

// File: rtl/riscv_dbg_pkg.sv
// Shared types for the debug run-control block: command opcodes, controller
// states and the GDB signal numbers reported back to the stub.
package riscv_dbg_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_HALT   = 3'd1,
    CMD_RESUME = 3'd2,
    CMD_STEP   = 3'd3,
    CMD_RESET  = 3'd4,
    CMD_BP_SET = 3'd5,
    CMD_BP_CLR = 3'd6
  } cmd_op_t;

  typedef enum logic [2:0] {
    RST,
    HREQ,
    HALTED,
    RLS,
    RUN,
    STEP
  } ctl_state_t;

  typedef logic [7:0] sig_t;

  localparam sig_t SIGINT  = 8'd2;
  localparam sig_t SIGILL  = 8'd4;
  localparam sig_t SIGTRAP = 8'd5;
  localparam sig_t SIGALRM = 8'd14;

  function automatic logic is_bp_op(input cmd_op_t op);
    return (op == CMD_BP_SET) || (op == CMD_BP_CLR);
  endfunction

endpackage

// File: rtl/riscv_dbg_bp.sv
// Hardware breakpoint bank: BPN address/enable slots and a combinational
// full-width match of the retiring PC against every enabled slot.
module riscv_dbg_bp
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPN  = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [XLEN-1:0] wr_adr,
  input  logic            wr_ena,
  input  logic [XLEN-1:0] ret_pc,
  output logic            hit
);

  logic [XLEN-1:0] adr_q [BPN];
  logic [BPN-1:0]  ena_q;

  // Indices past the last slot (non power-of-two BPN) match no slot and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BPN; i++) begin
        if (wr_idx == IDXW'(i)) begin
          ena_q[i] <= wr_ena;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BPN; i++) begin
        if (wr_idx == IDXW'(i)) begin
          adr_q[i] <= wr_adr;
        end
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < BPN; i++) begin
      if (ena_q[i] && (adr_q[i] == ret_pc)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_dbg_ctrl.sv
// Run-control sequencer between the GDB stub command port and the CPU
// halt handshake; reports every stop and halt-timeout with a signal code.
module riscv_dbg_ctrl
  import riscv_dbg_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int BPN     = 4,
  parameter  int RST_CYC = 4,
  parameter  int TMO     = 1024,
  localparam int IDXW    = (BPN > 1) ? $clog2(BPN) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic [2:0]      cmd_op,
  input  logic [IDXW-1:0] cmd_idx,
  input  logic [XLEN-1:0] cmd_adr,
  output logic            dbg_req,
  input  logic            dbg_grt,
  output logic            cpu_rst,
  input  logic            ret_vld,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            ret_ill,
  output logic            sts_vld,
  output logic [7:0]      sts_sig,
  output logic            sts_run
);

  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int TCW = $clog2(TMO + 1);

  ctl_state_t     state_q, state_d;
  sig_t           pend_q, pend_d;
  logic           step_q, step_d;
  logic [RCW-1:0] rst_cnt_q;
  logic [TCW-1:0] tmo_cnt_q;
  logic           sts_vld_q;
  sig_t           sts_sig_q;
  logic           ev_vld;
  sig_t           ev_sig;
  cmd_op_t        op;
  logic           bp_wr;
  logic           bp_hit;

  assign op    = cmd_op_t'(cmd_op);
  assign bp_wr = cmd_vld && cmd_rdy && is_bp_op(op);

  riscv_dbg_bp #(
    .XLEN (XLEN),
    .BPN  (BPN),
    .IDXW (IDXW)
  ) u_bp (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (bp_wr),
    .wr_idx (cmd_idx),
    .wr_adr (cmd_adr),
    .wr_ena (op == CMD_BP_SET),
    .ret_pc (ret_pc),
    .hit    (bp_hit)
  );

  // Stop causes in RUN are ranked illegal > breakpoint > HALT > RESET; a
  // command losing to a retire stop is still consumed.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    step_d  = step_q;
    ev_vld  = 1'b0;
    ev_sig  = sts_sig_q;
    dbg_req = 1'b0;
    cmd_rdy = 1'b0;
    cpu_rst = 1'b0;
    sts_run = 1'b0;
    case (state_q)
      RST: begin
        cpu_rst = 1'b1;
        dbg_req = 1'b1;
        if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
          state_d = HREQ;
          pend_d  = SIGTRAP;
        end
      end
      HREQ: begin
        dbg_req = 1'b1;
        if (dbg_grt) begin
          state_d = HALTED;
          ev_vld  = 1'b1;
          ev_sig  = pend_q;
        end else if (tmo_cnt_q == TCW'(TMO - 1)) begin
          ev_vld = 1'b1;
          ev_sig = SIGALRM;
        end
      end
      HALTED: begin
        dbg_req = 1'b1;
        cmd_rdy = 1'b1;
        if (cmd_vld) begin
          case (op)
            CMD_RESUME: begin
              state_d = RLS;
              step_d  = 1'b0;
            end
            CMD_STEP: begin
              state_d = RLS;
              step_d  = 1'b1;
            end
            CMD_RESET: state_d = RST;
            default:   state_d = HALTED;
          endcase
        end
      end
      RLS: begin
        if (!dbg_grt) begin
          state_d = step_q ? STEP : RUN;
        end
      end
      RUN: begin
        cmd_rdy = 1'b1;
        sts_run = 1'b1;
        if (ret_vld && ret_ill) begin
          state_d = HREQ;
          pend_d  = SIGILL;
        end else if (ret_vld && bp_hit) begin
          state_d = HREQ;
          pend_d  = SIGTRAP;
        end else if (cmd_vld && (op == CMD_HALT)) begin
          state_d = HREQ;
          pend_d  = SIGINT;
        end else if (cmd_vld && (op == CMD_RESET)) begin
          state_d = RST;
        end
      end
      STEP: begin
        sts_run = 1'b1;
        if (ret_vld) begin
          state_d = HREQ;
          pend_d  = ret_ill ? SIGILL : SIGTRAP;
        end
      end
      default: state_d = RST;
    endcase
  end

  // Counters restart on every entry into their state; the timeout saturates
  // so the alarm fires only once per halt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST;
      pend_q    <= SIGTRAP;
      step_q    <= 1'b0;
      rst_cnt_q <= '0;
      tmo_cnt_q <= '0;
      sts_vld_q <= 1'b0;
      sts_sig_q <= SIGTRAP;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      step_q    <= step_d;
      rst_cnt_q <= ((state_q == RST) && (state_d == RST)) ? rst_cnt_q + RCW'(1) : '0;
      if ((state_q == HREQ) && (state_d == HREQ)) begin
        if (tmo_cnt_q != TCW'(TMO)) begin
          tmo_cnt_q <= tmo_cnt_q + TCW'(1);
        end
      end else begin
        tmo_cnt_q <= '0;
      end
      sts_vld_q <= ev_vld;
      if (ev_vld) begin
        sts_sig_q <= ev_sig;
      end
    end
  end

  assign sts_vld = sts_vld_q;
  assign sts_sig = sts_sig_q;

endmodule

// File: tb/tb_riscv_dbg_ctrl.sv
// Self-checking bench for riscv_dbg_ctrl: directed run-control scenarios plus
// randomized retire streams scored against a breakpoint/stop reference model.
module tb_riscv_dbg_ctrl;

  localparam int XLEN    = 32;
  localparam int BPN     = 4;
  localparam int RST_CYC = 4;
  localparam int TMO     = 1024;
  localparam int IDXW    = $clog2(BPN);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_RESUME = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_RESET  = 3'd4;
  localparam logic [2:0] OP_BP_SET = 3'd5;
  localparam logic [2:0] OP_BP_CLR = 3'd6;

  localparam logic [7:0] S_INT  = 8'h02;
  localparam logic [7:0] S_ILL  = 8'h04;
  localparam logic [7:0] S_TRAP = 8'h05;
  localparam logic [7:0] S_ALRM = 8'h0E;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_vld = 1'b0;
  logic            cmd_rdy;
  logic [2:0]      cmd_op = OP_NOP;
  logic [IDXW-1:0] cmd_idx = '0;
  logic [XLEN-1:0] cmd_adr = '0;
  logic            dbg_req;
  logic            dbg_grt = 1'b0;
  logic            cpu_rst;
  logic            ret_vld = 1'b0;
  logic [XLEN-1:0] ret_pc = '0;
  logic            ret_ill = 1'b0;
  logic            sts_vld;
  logic [7:0]      sts_sig;
  logic            sts_run;

  int   n_vec = 0;
  int   n_err = 0;
  bit   grt_en = 1'b1;
  logic req_last = 1'b0;

  // Reference breakpoint table, updated whenever a BP command is transferred.
  logic [XLEN-1:0] m_adr [BPN];
  bit              m_en  [BPN];

  riscv_dbg_ctrl #(
    .XLEN    (XLEN),
    .BPN     (BPN),
    .RST_CYC (RST_CYC),
    .TMO     (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_op  (cmd_op),
    .cmd_idx (cmd_idx),
    .cmd_adr (cmd_adr),
    .dbg_req (dbg_req),
    .dbg_grt (dbg_grt),
    .cpu_rst (cpu_rst),
    .ret_vld (ret_vld),
    .ret_pc  (ret_pc),
    .ret_ill (ret_ill),
    .sts_vld (sts_vld),
    .sts_sig (sts_sig),
    .sts_run (sts_run)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exhausted, got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one cycle; the CPU acknowledges by echoing dbg_req one cycle late.
  task automatic cycle();
    @(posedge clk);
    #1;
    dbg_grt  = grt_en ? req_last : 1'b0;
    req_last = dbg_req;
  endtask

  function automatic logic [7:0] exp_stop(input logic vld, input logic ill, input logic [XLEN-1:0] pc);
    if (!vld) return 8'h00;
    if (ill) return S_ILL;
    for (int i = 0; i < BPN; i++) begin
      if (m_en[i] && (m_adr[i] == pc)) return S_TRAP;
    end
    return 8'h00;
  endfunction

  task automatic send(input logic [2:0] op, input int idx, input logic [XLEN-1:0] adr);
    int w = 0;
    while (!cmd_rdy && w < 50) begin
      cycle();
      w++;
    end
    if (cmd_rdy !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL cmd_accept op%0d: cmd_rdy=%b want 1", op, cmd_rdy);
    end else begin
      cmd_vld = 1'b1;
      cmd_op  = op;
      cmd_idx = IDXW'(idx);
      cmd_adr = adr;
      cycle();
      cmd_vld = 1'b0;
      cmd_op  = OP_NOP;
      if (op == OP_BP_SET) begin
        m_en[idx]  = 1'b1;
        m_adr[idx] = adr;
      end else if (op == OP_BP_CLR) begin
        m_en[idx] = 1'b0;
      end
    end
  endtask

  task automatic wait_vld(input int max, output bit got, output logic [7:0] sig);
    got = 1'b0;
    sig = 8'hxx;
    for (int i = 0; i < max && !got; i++) begin
      if (sts_vld === 1'b1) begin
        got = 1'b1;
        sig = sts_sig;
      end else begin
        cycle();
      end
    end
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (sts_run === 1'b1 && dbg_req === 1'b0) ok = 1'b1;
      else cycle();
    end
  endtask

  task automatic test_reset();
    int high;
    bit got;
    logic [7:0] sig;
    rst = 1'b1;
    cycle();
    cycle();
    n_vec++;
    if (cpu_rst !== 1'b1 || dbg_req !== 1'b1 || cmd_rdy !== 1'b0 || sts_vld !== 1'b0 || sts_run !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: cpu_rst=%b dbg_req=%b cmd_rdy=%b sts_vld=%b sts_run=%b want 1 1 0 0 0",
               cpu_rst, dbg_req, cmd_rdy, sts_vld, sts_run);
    end
    n_vec++;
    if (sts_sig !== S_TRAP) begin
      n_err++;
      $display("[TB] FAIL reset_sig: got %0h want %0h", sts_sig, S_TRAP);
    end
    rst  = 1'b0;
    high = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (cpu_rst === 1'b1) high++;
      else break;
    end
    n_vec++;
    if (high != RST_CYC) begin
      n_err++;
      $display("[TB] FAIL cpu_rst_len: got %0d cycles want %0d", high, RST_CYC);
    end
    wait_vld(10, got, sig);
    n_vec++;
    if (!got || sig !== S_TRAP) begin
      n_err++;
      $display("[TB] FAIL reset_stop: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, S_TRAP);
    end
    n_vec++;
    if (cmd_rdy !== 1'b1 || dbg_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_halted: cmd_rdy=%b dbg_req=%b want 1 1", cmd_rdy, dbg_req);
    end
  endtask

  task automatic test_resume_halt();
    bit ok, got;
    logic [7:0] sig;
    grt_en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    n_vec++;
    if (cmd_rdy !== 1'b1 || dbg_req !== 1'b1 || sts_run !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL halted_grt_drop: cmd_rdy=%b dbg_req=%b sts_run=%b want 1 1 0", cmd_rdy, dbg_req, sts_run);
    end
    grt_en = 1'b1;
    cycle();
    send(OP_RESUME, 0, '0);
    wait_run(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("[TB] FAIL resume_run: sts_run=%b dbg_req=%b want 1 0", sts_run, dbg_req);
    end
    send(OP_HALT, 0, '0);
    n_vec++;
    if (dbg_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL halt_req: dbg_req=%b want 1", dbg_req);
    end
    wait_vld(10, got, sig);
    n_vec++;
    if (!got || sig !== S_INT) begin
      n_err++;
      $display("[TB] FAIL halt_stop: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, S_INT);
    end
  endtask

  task automatic test_breakpoint();
    logic [XLEN-1:0] pcs [3];
    logic            want [3];
    bit ok, got;
    logic [7:0] sig;
    pcs[0] = 32'h0000_00F8; want[0] = 1'b0;
    pcs[1] = 32'h0000_00FC; want[1] = 1'b0;
    pcs[2] = 32'h0000_0100; want[2] = 1'b1;
    send(OP_BP_SET, 0, 32'h0000_0100);
    send(OP_RESUME, 0, '0);
    wait_run(ok);
    for (int i = 0; i < 3; i++) begin
      ret_vld = 1'b1;
      ret_pc  = pcs[i];
      cycle();
      ret_vld = 1'b0;
      n_vec++;
      if (dbg_req !== want[i]) begin
        n_err++;
        $display("[TB] FAIL bp_req pc=%0h: dbg_req=%b want %b", pcs[i], dbg_req, want[i]);
      end
    end
    wait_vld(10, got, sig);
    n_vec++;
    if (!got || sig !== S_TRAP) begin
      n_err++;
      $display("[TB] FAIL bp_stop: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, S_TRAP);
    end
    send(OP_BP_CLR, 0, 32'h0000_0100);
    send(OP_RESUME, 0, '0);
    wait_run(ok);
    ret_vld = 1'b1;
    ret_pc  = 32'h0000_0100;
    cycle();
    ret_vld = 1'b0;
    cycle();
    n_vec++;
    if (dbg_req !== 1'b0 || sts_run !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL bp_cleared: dbg_req=%b sts_run=%b want 0 1", dbg_req, sts_run);
    end
    send(OP_HALT, 0, '0);
    wait_vld(10, got, sig);
    n_vec++;
    if (!got || sig !== S_INT) begin
      n_err++;
      $display("[TB] FAIL bp_cleared_halt: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, S_INT);
    end
  endtask

  task automatic test_step();
    bit got, ill;
    int n;
    logic [7:0] sig;
    for (int r = 0; r < 4; r++) begin
      ill = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      send(OP_STEP, 0, '0);
      for (int i = 0; i < 10 && sts_run !== 1'b1; i++) cycle();
      n_vec++;
      if (sts_run !== 1'b1 || cmd_rdy !== 1'b0 || dbg_req !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL step_state: sts_run=%b cmd_rdy=%b dbg_req=%b want 1 0 0", sts_run, cmd_rdy, dbg_req);
      end
      n = 0;
      for (int i = 0; i < 10; i++) begin
        if (dbg_req === 1'b1) break;
        ret_vld = 1'b1;
        ret_ill = (i == 0) ? ill : 1'b0;
        ret_pc  = 32'h0000_0104 + 32'(4 * i);
        n++;
        cycle();
      end
      ret_vld = 1'b0;
      ret_ill = 1'b0;
      n_vec++;
      if (n != 1) begin
        n_err++;
        $display("[TB] FAIL step_count: got %0d retires want 1", n);
      end
      wait_vld(10, got, sig);
      n_vec++;
      if (!got || sig !== (ill ? S_ILL : S_TRAP)) begin
        n_err++;
        $display("[TB] FAIL step_sig: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, ill ? S_ILL : S_TRAP);
      end
    end
  endtask

  task automatic test_priority();
    logic [XLEN-1:0] a;
    logic [7:0] es, sig;
    bit ok, got;
    a = {$urandom} & 32'hFFFF_FFFC;
    send(OP_BP_SET, 2, a);
    for (int r = 0; r < 2; r++) begin
      es = (r == 0) ? S_ILL : S_TRAP;
      send(OP_RESUME, 0, '0);
      wait_run(ok);
      ret_vld = 1'b1;
      ret_ill = (r == 0);
      ret_pc  = a;
      cmd_vld = 1'b1;
      cmd_op  = OP_HALT;
      cycle();
      ret_vld = 1'b0;
      ret_ill = 1'b0;
      cmd_vld = 1'b0;
      cmd_op  = OP_NOP;
      n_vec++;
      if (dbg_req !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL prio_req r%0d: dbg_req=%b want 1", r, dbg_req);
      end
      wait_vld(10, got, sig);
      n_vec++;
      if (!got || sig !== es) begin
        n_err++;
        $display("[TB] FAIL prio_sig r%0d: got vld=%b sig=%0h want vld=1 sig=%0h", r, got, sig, es);
      end
    end
  endtask

  task automatic test_random_bp();
    logic [7:0] es, sig;
    bit ok, got, stopped;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < BPN; i++) begin
        logic [XLEN-1:0] a;
        a = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 2) != 0) send(OP_BP_SET, i, a);
        else send(OP_BP_CLR, i, a);
      end
      send(OP_RESUME, 0, '0);
      wait_run(ok);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("[TB] FAIL rand_resume r%0d: sts_run=%b dbg_req=%b want 1 0", r, sts_run, dbg_req);
      end
      stopped = 1'b0;
      es = 8'h00;
      for (int c = 0; c < 40 && !stopped; c++) begin
        ret_vld = 1'($urandom_range(0, 1));
        ret_ill = ($urandom_range(0, 15) == 0);
        ret_pc  = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32'd4;
        es = exp_stop(ret_vld, ret_ill, ret_pc);
        cycle();
        ret_vld = 1'b0;
        ret_ill = 1'b0;
        n_vec++;
        if (es != 8'h00) begin
          stopped = 1'b1;
          if (dbg_req !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rand_stop_req r%0d c%0d: dbg_req=%b want 1", r, c, dbg_req);
          end
        end else if (dbg_req !== 1'b0 || sts_run !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL rand_running r%0d c%0d: dbg_req=%b sts_run=%b want 0 1", r, c, dbg_req, sts_run);
        end
      end
      if (!stopped) begin
        send(OP_HALT, 0, '0);
        es = S_INT;
      end
      wait_vld(10, got, sig);
      n_vec++;
      if (!got || sig !== es) begin
        n_err++;
        $display("[TB] FAIL rand_sig r%0d: got vld=%b sig=%0h want vld=1 sig=%0h", r, got, sig, es);
      end
    end
  endtask

  task automatic test_timeout();
    int alarms, alarm_k;
    logic [7:0] alarm_sig, sig;
    bit ok, got;
    send(OP_RESUME, 0, '0);
    wait_run(ok);
    grt_en = 1'b0;
    send(OP_HALT, 0, '0);
    alarms    = 0;
    alarm_k   = -1;
    alarm_sig = 8'h00;
    for (int k = 0; k <= TMO + 10; k++) begin
      if (sts_vld === 1'b1) begin
        alarms++;
        alarm_k   = k;
        alarm_sig = sts_sig;
      end
      cycle();
    end
    n_vec++;
    if (alarms != 1 || alarm_k != TMO) begin
      n_err++;
      $display("[TB] FAIL tmo_pulse: got %0d pulses at %0d want 1 at %0d", alarms, alarm_k, TMO);
    end
    n_vec++;
    if (alarm_sig !== S_ALRM || sts_sig !== S_ALRM) begin
      n_err++;
      $display("[TB] FAIL tmo_sig: got %0h held %0h want %0h", alarm_sig, sts_sig, S_ALRM);
    end
    n_vec++;
    if (dbg_req !== 1'b1 || cmd_rdy !== 1'b0 || sts_run !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL tmo_hreq: dbg_req=%b cmd_rdy=%b sts_run=%b want 1 0 0", dbg_req, cmd_rdy, sts_run);
    end
    grt_en = 1'b1;
    wait_vld(10, got, sig);
    n_vec++;
    if (!got || sig !== S_INT) begin
      n_err++;
      $display("[TB] FAIL tmo_grant: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, S_INT);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    logic [7:0] sig;
    send(OP_BP_SET, 1, 32'h0000_0200);
    send(OP_RESUME, 0, '0);
    wait_run(ok);
    send(OP_HALT, 0, '0);
    cycle();
    rst = 1'b1;
    cycle();
    n_vec++;
    if (sts_vld !== 1'b0 || cpu_rst !== 1'b1 || cmd_rdy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rst_abort: sts_vld=%b cpu_rst=%b cmd_rdy=%b want 0 1 0", sts_vld, cpu_rst, cmd_rdy);
    end
    rst = 1'b0;
    for (int i = 0; i < BPN; i++) m_en[i] = 1'b0;
    wait_vld(20, got, sig);
    n_vec++;
    if (!got || sig !== S_TRAP) begin
      n_err++;
      $display("[TB] FAIL rst_restart: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, S_TRAP);
    end
    send(OP_RESUME, 0, '0);
    wait_run(ok);
    ret_vld = 1'b1;
    ret_pc  = 32'h0000_0200;
    cycle();
    ret_vld = 1'b0;
    n_vec++;
    if (dbg_req !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rst_bp_cleared: dbg_req=%b want 0", dbg_req);
    end
    send(OP_RESET, 0, '0);
    n_vec++;
    if (cpu_rst !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL run_reset_cmd: cpu_rst=%b want 1", cpu_rst);
    end
    wait_vld(20, got, sig);
    n_vec++;
    if (!got || sig !== S_TRAP) begin
      n_err++;
      $display("[TB] FAIL run_reset_stop: got vld=%b sig=%0h want vld=1 sig=%0h", got, sig, S_TRAP);
    end
  endtask

  initial begin
    for (int i = 0; i < BPN; i++) begin
      m_en[i]  = 1'b0;
      m_adr[i] = '0;
    end
    $display("[TB] riscv_dbg_ctrl bench start");
    test_reset();
    test_resume_halt();
    test_breakpoint();
    test_step();
    test_priority();
    test_random_bp();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
